// File: rtl/ps2_host_tx_if.sv
// Command handshake and transfer status between a command source and ps2_host_tx.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  done,
        input  ack_ok
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output done,
        output ack_ok
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send, shifts one
// command byte out on device clock falling edges and checks the device ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYC = 3360,
    parameter int unsigned TIMEOUT_CYC = 420000
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_kbd_clk,
    input  logic         ps2_kbd_data,
    output logic         ps2_clk_drive,
    output logic         ps2_data_drive
);
    localparam logic [19:0] InhibitLim = 20'(INHIBIT_CYC);
    localparam logic [19:0] TimeoutLim = 20'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StBits,
        StAck,
        StWaitIdle,
        StDone
    } state_e;

    logic [1:0]  clk_sync_q, data_sync_q;
    logic [3:0]  clk_win_q, data_win_q;
    logic        clk_filt_q, data_filt_q;
    logic        clk_filt_d, data_filt_d;
    logic        dev_fall;

    state_e      state_q;
    logic [7:0]  shift_q;
    logic        parity_q;
    logic [19:0] inh_cnt_q, to_cnt_q;
    logic [19:0] inh_inc, to_inc;
    logic        to_hit;
    logic [3:0]  edge_cnt_q;
    logic        ack_seen_q;
    logic        clk_drive_q, data_drive_q;
    logic        ready_q, busy_q, done_q, ack_ok_q;

    // Line synchronisers and 4-sample history windows; lines idle high.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_win_q   <= 4'hf;
            data_win_q  <= 4'hf;
            clk_filt_q  <= 1'b1;
            data_filt_q <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_kbd_clk};
            data_sync_q <= {data_sync_q[0], ps2_kbd_data};
            clk_win_q   <= {clk_win_q[2:0], clk_sync_q[1]};
            data_win_q  <= {data_win_q[2:0], data_sync_q[1]};
            clk_filt_q  <= clk_filt_d;
            data_filt_q <= data_filt_d;
        end
    end

    // Filtered level moves only once the whole window agrees; also counter increments.
    always_comb begin
        clk_filt_d = clk_filt_q;
        if (&clk_win_q) begin
            clk_filt_d = 1'b1;
        end else if (~|clk_win_q) begin
            clk_filt_d = 1'b0;
        end
        data_filt_d = data_filt_q;
        if (&data_win_q) begin
            data_filt_d = 1'b1;
        end else if (~|data_win_q) begin
            data_filt_d = 1'b0;
        end
        dev_fall = clk_filt_q & ~clk_filt_d;
        inh_inc  = (&inh_cnt_q) ? inh_cnt_q : inh_cnt_q + 20'd1;
        to_inc   = (&to_cnt_q) ? to_cnt_q : to_cnt_q + 20'd1;
        to_hit   = (to_inc >= TimeoutLim);
    end

    // Transfer FSM with registered line drives and status outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            inh_cnt_q    <= '0;
            to_cnt_q     <= '0;
            edge_cnt_q   <= '0;
            ack_seen_q   <= 1'b0;
            clk_drive_q  <= 1'b0;
            data_drive_q <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ack_ok_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (tx.tx_valid && ready_q) begin
                        shift_q      <= tx.tx_data;
                        parity_q     <= ~^tx.tx_data;
                        inh_cnt_q    <= 20'd1;
                        clk_drive_q  <= 1'b1;
                        // Degenerate one-cycle inhibit still needs the overlap cycle.
                        data_drive_q <= (InhibitLim <= 20'd1);
                        ready_q      <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= StInhibit;
                    end
                end
                StInhibit: begin
                    if (inh_cnt_q >= InhibitLim) begin
                        clk_drive_q <= 1'b0;
                        to_cnt_q    <= '0;
                        edge_cnt_q  <= '0;
                        state_q     <= StBits;
                    end else begin
                        inh_cnt_q <= inh_inc;
                        // Start bit goes low in the last inhibit cycle (request-to-send).
                        if (inh_inc >= InhibitLim) begin
                            data_drive_q <= 1'b1;
                        end
                    end
                end
                StBits: begin
                    if (dev_fall) begin
                        to_cnt_q   <= '0;
                        edge_cnt_q <= edge_cnt_q + 4'd1;
                        if (edge_cnt_q < 4'd8) begin
                            data_drive_q <= ~shift_q[0];
                            shift_q      <= {1'b0, shift_q[7:1]};
                        end else if (edge_cnt_q == 4'd8) begin
                            data_drive_q <= ~parity_q;
                        end else begin
                            data_drive_q <= 1'b0;
                            state_q      <= StAck;
                        end
                    end else if (to_hit) begin
                        clk_drive_q  <= 1'b0;
                        data_drive_q <= 1'b0;
                        done_q       <= 1'b1;
                        ack_ok_q     <= 1'b0;
                        state_q      <= StDone;
                    end else begin
                        to_cnt_q <= to_inc;
                    end
                end
                StAck: begin
                    if (dev_fall) begin
                        to_cnt_q   <= '0;
                        ack_seen_q <= ~data_filt_q;
                        state_q    <= StWaitIdle;
                    end else if (to_hit) begin
                        data_drive_q <= 1'b0;
                        done_q       <= 1'b1;
                        ack_ok_q     <= 1'b0;
                        state_q      <= StDone;
                    end else begin
                        to_cnt_q <= to_inc;
                    end
                end
                StWaitIdle: begin
                    if (clk_filt_q && data_filt_q) begin
                        done_q   <= 1'b1;
                        ack_ok_q <= ack_seen_q;
                        state_q  <= StDone;
                    end else if (dev_fall) begin
                        to_cnt_q <= '0;
                    end else if (to_hit) begin
                        data_drive_q <= 1'b0;
                        done_q       <= 1'b1;
                        ack_ok_q     <= 1'b0;
                        state_q      <= StDone;
                    end else begin
                        to_cnt_q <= to_inc;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    clk_drive_q  <= 1'b0;
                    data_drive_q <= 1'b0;
                    ready_q      <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

    assign ps2_clk_drive  = clk_drive_q;
    assign ps2_data_drive = data_drive_q;
    assign tx.tx_ready    = ready_q;
    assign tx.busy        = busy_q;
    assign tx.done        = done_q;
    assign tx.ack_ok      = ack_ok_q;

endmodule
